// File: rtl/gshare_bp_if.sv
// Predictor-facing bundle: fetch-side lookup and ROB-side commit signals.
//
// Handshake semantics: there is no backpressure on either side. A fetch
// lookup is "valid" in any cycle where in_fetcher_br=1 and is consumed on
// the same rising edge when rdy=1 and out_ready=1. A commit is "valid" when
// in_rob_bp=1 and is likewise consumed on that edge under the same
// qualification. out_ready acts as the predictor's ready: while it is low,
// both fetch shifts and commits are dropped.
interface gshare_bp_if #(
    parameter int IDX_W = 8,
    parameter int GHR_W = 8
);
    logic [IDX_W-1:0] in_fetcher_tag;
    logic             in_fetcher_br;
    logic             out_fetcher_jump;
    logic [GHR_W-1:0] out_fetcher_ghr;
    logic             out_ready;
    logic             in_rob_bp;
    logic             in_rob_jump;
    logic [IDX_W-1:0] in_rob_tag;
    logic [GHR_W-1:0] in_rob_ghr;
    logic             in_rob_mispredict;

    modport master (
        output in_fetcher_tag, in_fetcher_br,
        output in_rob_bp, in_rob_jump, in_rob_tag, in_rob_ghr, in_rob_mispredict,
        input  out_fetcher_jump, out_fetcher_ghr, out_ready
    );

    modport slave (
        input  in_fetcher_tag, in_fetcher_br,
        input  in_rob_bp, in_rob_jump, in_rob_tag, in_rob_ghr, in_rob_mispredict,
        output out_fetcher_jump, out_fetcher_ghr, out_ready
    );
endinterface

// File: rtl/gshare_bp.sv
// Gshare branch predictor: a table of saturating counters indexed by
// tag XOR global history. The table is cleared to weakly-not-taken by a
// sequential INIT sweep after reset, one entry per enabled cycle.
module gshare_bp #(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2,
    parameter int GHR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    gshare_bp_if.slave  bp,
    output logic        o_dbg_state
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int              ENTRIES  = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [GHR_W-1:0] r_ghr;
    logic [GHR_W-1:0] w_ghr_nxt;
    logic [CTR_W-1:0] r_table [ENTRIES];

    logic             w_run;
    logic             w_commit;
    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_rob_idx;
    logic [CTR_W-1:0] w_fetch_ctr;
    logic [CTR_W-1:0] w_rob_ctr;
    logic [CTR_W-1:0] w_rob_ctr_nxt;
    logic             w_pred;

    assign w_run       = (r_state == ST_RUN) && !rst;
    assign w_commit    = w_run && rdy && bp.in_rob_bp;
    // History lives in the low bits of the index; prediction uses the live
    // GHR, training uses the snapshot that travelled with the branch.
    assign w_fetch_idx = bp.in_fetcher_tag ^ IDX_W'(r_ghr);
    assign w_rob_idx   = bp.in_rob_tag ^ IDX_W'(bp.in_rob_ghr);
    assign w_fetch_ctr = r_table[w_fetch_idx];
    assign w_rob_ctr   = r_table[w_rob_idx];
    // Read is from the pre-update array, so a same-cycle commit is not seen.
    assign w_pred      = w_run && w_fetch_ctr[CTR_W-1];

    assign bp.out_fetcher_jump = w_pred;
    assign bp.out_fetcher_ghr  = rst ? '0 : r_ghr;
    assign bp.out_ready        = w_run;
    assign o_dbg_state         = r_state;

    // Next-state: INIT ends once the last entry is written; RUN is terminal.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && rdy && r_ptr == '1) begin
            w_state_nxt = ST_RUN;
        end
    end

    // State register and INIT sweep pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT && rdy) begin
                r_ptr <= r_ptr + IDX_W'(1);
            end
        end
    end

    // Saturating counter step for the committing branch.
    always_comb begin
        w_rob_ctr_nxt = w_rob_ctr;
        if (bp.in_rob_jump) begin
            if (w_rob_ctr != CTR_MAX) w_rob_ctr_nxt = w_rob_ctr + CTR_W'(1);
        end else begin
            if (w_rob_ctr != '0) w_rob_ctr_nxt = w_rob_ctr - CTR_W'(1);
        end
    end

    // History update: misprediction recovery wins over a speculative shift.
    always_comb begin
        w_ghr_nxt = r_ghr;
        if (w_run && rdy) begin
            if (bp.in_rob_bp && bp.in_rob_mispredict) begin
                w_ghr_nxt = GHR_W'({bp.in_rob_ghr, bp.in_rob_jump});
            end else if (bp.in_fetcher_br) begin
                w_ghr_nxt = GHR_W'({r_ghr, w_pred});
            end
        end
    end

    // Global history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_nxt;
        end
    end

    // Single table write port: INIT sweep or commit training.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (r_state == ST_INIT) begin
                r_table[r_ptr] <= CTR_INIT;
            end else if (w_commit) begin
                r_table[w_rob_idx] <= w_rob_ctr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp (IDX_W=8, CTR_W=2, GHR_W=8).
module tb_gshare_bp;
    logic clk;
    logic rst;
    logic rdy;
    logic dbg_state;
    int   n_assert;
    int   n_fail;
    int   cnt;

    // Saturation walk on entry 3: commit directions and the prediction
    // expected after each commit, starting from weakly-not-taken (01).
    logic sat_dir [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic sat_exp [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    gshare_bp_if #(.IDX_W(8), .GHR_W(8)) bp_if ();

    gshare_bp #(.IDX_W(8), .CTR_W(2), .GHR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .bp          (bp_if),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic commit(input logic [7:0] tag, input logic [7:0] ghr, input logic dir);
        bp_if.in_rob_bp         = 1'b1;
        bp_if.in_rob_tag        = tag;
        bp_if.in_rob_ghr        = ghr;
        bp_if.in_rob_jump       = dir;
        bp_if.in_rob_mispredict = 1'b0;
        cyc(1);
        bp_if.in_rob_bp = 1'b0;
    endtask

    task automatic pred_check(input string tag, input logic [7:0] ftag, input logic exp_v);
        bp_if.in_fetcher_tag = ftag;
        #1;
        check(tag, {31'd0, bp_if.out_fetcher_jump}, {31'd0, exp_v});
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bp_if.out_ready && n < 400) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        rdy = 1'b1;
        bp_if.in_fetcher_tag    = '0;
        bp_if.in_fetcher_br     = 1'b0;
        bp_if.in_rob_bp         = 1'b0;
        bp_if.in_rob_jump       = 1'b0;
        bp_if.in_rob_tag        = '0;
        bp_if.in_rob_ghr        = '0;
        bp_if.in_rob_mispredict = 1'b0;

        // Reset state
        cyc(1);
        check("rst_ready", {31'd0, bp_if.out_ready}, 32'd0);
        check("rst_jump", {31'd0, bp_if.out_fetcher_jump}, 32'd0);
        check("rst_ghr", {24'd0, bp_if.out_fetcher_ghr}, 32'd0);
        check("rst_state", {31'd0, dbg_state}, 32'd0);
        rst = 1'b0;

        // Init length: exactly 2^IDX_W enabled cycles
        wait_ready(cnt);
        check("init_len", cnt, 32'd256);
        check("run_state", {31'd0, dbg_state}, 32'd1);
        for (int t = 0; t < 256; t++) begin
            pred_check("init_entry", 8'(t), 1'b0);
        end

        // Saturation on entry 3 (GHR=0)
        for (int i = 0; i < 12; i++) begin
            commit(8'd3, 8'd0, sat_dir[i]);
            pred_check("sat_step", 8'd3, sat_exp[i]);
        end

        // Same-cycle fetch and commit: prediction sees old value (10 -> 01)
        bp_if.in_fetcher_tag = 8'd3;
        bp_if.in_rob_bp      = 1'b1;
        bp_if.in_rob_tag     = 8'd3;
        bp_if.in_rob_ghr     = 8'd0;
        bp_if.in_rob_jump    = 1'b0;
        #1;
        check("nobypass_pre", {31'd0, bp_if.out_fetcher_jump}, 32'd1);
        cyc(1);
        bp_if.in_rob_bp = 1'b0;
        pred_check("nobypass_post", 8'd3, 1'b0);

        // Entry 3 to strongly taken (01 -> 10 -> 11)
        commit(8'd3, 8'd0, 1'b1);
        commit(8'd3, 8'd0, 1'b1);
        pred_check("entry3_taken", 8'd3, 1'b1);

        // Speculative shift: predictions 1,0,1
        bp_if.in_fetcher_br = 1'b1;
        pred_check("spec_p1", 8'd3, 1'b1);
        cyc(1);
        check("spec_ghr1", {24'd0, bp_if.out_fetcher_ghr}, 32'h01);
        pred_check("spec_p2", 8'd0, 1'b0);
        cyc(1);
        check("spec_ghr2", {24'd0, bp_if.out_fetcher_ghr}, 32'h02);
        pred_check("spec_p3", 8'd1, 1'b1);
        cyc(1);
        check("spec_ghr3", {24'd0, bp_if.out_fetcher_ghr}, 32'h05);

        // Recovery beats same-cycle fetch shift; commit trains entry 0 (01 -> 10)
        bp_if.in_fetcher_tag    = 8'd3;
        bp_if.in_rob_bp         = 1'b1;
        bp_if.in_rob_mispredict = 1'b1;
        bp_if.in_rob_ghr        = 8'h3C;
        bp_if.in_rob_tag        = 8'h3C;
        bp_if.in_rob_jump       = 1'b1;
        cyc(1);
        bp_if.in_fetcher_br     = 1'b0;
        bp_if.in_rob_bp         = 1'b0;
        bp_if.in_rob_mispredict = 1'b0;
        check("recover_ghr", {24'd0, bp_if.out_fetcher_ghr}, 32'h79);
        pred_check("recover_entry0", 8'h79, 1'b1);
        pred_check("recover_entry1", 8'h78, 1'b0);

        // Mispredict without a commit is ignored
        bp_if.in_rob_mispredict = 1'b1;
        bp_if.in_rob_ghr        = 8'hAA;
        bp_if.in_rob_jump       = 1'b0;
        cyc(1);
        bp_if.in_rob_mispredict = 1'b0;
        check("lone_mispredict", {24'd0, bp_if.out_fetcher_ghr}, 32'h79);

        // rdy=0: no GHR change, no table write, outputs still combinational
        rdy = 1'b0;
        bp_if.in_fetcher_br  = 1'b1;
        bp_if.in_rob_bp      = 1'b1;
        bp_if.in_rob_tag     = 8'h3C;
        bp_if.in_rob_ghr     = 8'h3C;
        bp_if.in_rob_jump    = 1'b0;
        cyc(3);
        check("stall_ghr", {24'd0, bp_if.out_fetcher_ghr}, 32'h79);
        pred_check("stall_comb", 8'h78, 1'b0);
        rdy = 1'b1;
        bp_if.in_fetcher_br = 1'b0;
        bp_if.in_rob_bp     = 1'b0;
        pred_check("stall_no_write", 8'h79, 1'b1);

        // Aliasing: tag5/ghr0 and tag4/ghr1 both land on entry 5
        commit(8'd5, 8'd0, 1'b1);
        pred_check("alias_1", 8'h7C, 1'b1);
        commit(8'd4, 8'd1, 1'b1);
        pred_check("alias_2", 8'h7C, 1'b1);
        commit(8'd5, 8'd0, 1'b0);
        pred_check("alias_3", 8'h7C, 1'b1);
        commit(8'd4, 8'd1, 1'b0);
        pred_check("alias_4", 8'h7C, 1'b0);

        // Reset from RUN, then reset again at pointer=7
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rerst_ready", {31'd0, bp_if.out_ready}, 32'd0);
        check("rerst_ghr", {24'd0, bp_if.out_fetcher_ghr}, 32'd0);
        cyc(7);
        pred_check("midinit_jump", 8'd3, 1'b0);
        check("midinit_ready", {31'd0, bp_if.out_ready}, 32'd0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        wait_ready(cnt);
        check("midinit_len", cnt, 32'd256);
        pred_check("reinit_entry3", 8'd3, 1'b0);
        pred_check("reinit_entry0", 8'd0, 1'b0);

        // INIT stretched by three stalled cycles
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cnt = 0;
        while (!bp_if.out_ready && cnt < 400) begin
            rdy = !(cnt >= 10 && cnt < 13);
            cyc(1);
            cnt++;
        end
        rdy = 1'b1;
        check("stall_init_len", cnt, 32'd259);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gshare_bp.md
GSHARE_BP -- requirements
Module: gshare_bp

Interface
REQ-001 Parameter IDX_W, default 8, sets the table index width; the table has 2^IDX_W entries.
REQ-002 Parameter CTR_W, default 2, sets the saturating counter width; legal range 2..4.
REQ-003 Parameter GHR_W, default 8, sets the global history width; legal range 1..IDX_W.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global enable; when low, all state holds.
REQ-007 in_fetcher_tag  in  IDX_W  branch tag (PC bits) of the instruction being fetched.
REQ-008 in_fetcher_br  in  1  fetched instruction is a B-type branch this cycle.
REQ-009 out_fetcher_jump  out  1  predicted direction, taken=1.
REQ-010 out_fetcher_ghr  out  GHR_W  history snapshot used for this prediction; fetcher carries it to the ROB.
REQ-011 out_ready  out  1  table initialised; predictions valid.
REQ-012 in_rob_bp  in  1  a B-type branch commits this cycle.
REQ-013 in_rob_jump  in  1  actual direction of the committing branch.
REQ-014 in_rob_tag  in  IDX_W  tag of the committing branch.
REQ-015 in_rob_ghr  in  GHR_W  snapshot returned with the committing branch.
REQ-016 in_rob_mispredict  in  1  committing branch was mispredicted; the pipeline flushes.

Function
REQ-017 Index formation: idx = tag XOR zero-extended history (history in the low GHR_W bits); prediction uses the live GHR, update uses in_rob_ghr.
REQ-018 out_fetcher_jump = MSB of counter[fetch idx], combinational; out_fetcher_ghr = live GHR, combinational.
REQ-019 State INIT: an IDX_W-bit pointer writes 2^(CTR_W-1)-1 (weakly not-taken) to one entry per rdy cycle, starting at 0.
REQ-020 INIT lasts exactly 2^IDX_W rdy cycles, then the FSM enters RUN.
REQ-021 During INIT: out_ready=0, out_fetcher_jump=0, and ROB updates and GHR shifts are ignored.
REQ-022 RUN is terminal until rst; out_ready=1 in RUN.
REQ-023 Commit update (RUN, rdy, in_rob_bp=1): counter[in_rob_tag XOR in_rob_ghr] increments if in_rob_jump=1 and decrements if 0.
REQ-024 Counters saturate at 2^CTR_W-1 and at 0; they never wrap.
REQ-025 Speculative history (RUN, rdy, in_fetcher_br=1, no mispredict): GHR <= {GHR[GHR_W-2:0], out_fetcher_jump}; for GHR_W=1, GHR <= out_fetcher_jump.
REQ-026 Recovery (RUN, rdy, in_rob_bp=1, in_rob_mispredict=1): GHR <= {in_rob_ghr[GHR_W-2:0], in_rob_jump}; this has priority over a same-cycle fetch shift.
REQ-027 in_rob_mispredict with in_rob_bp=0 is ignored.
REQ-028 Same-cycle fetch and commit to the same index: the prediction uses the pre-update value; there is no bypass.
REQ-029 rdy=0: no table write, no GHR change, and the INIT pointer holds; combinational outputs still track their inputs.

Reset
REQ-030 rst=1 at an edge: FSM enters INIT, pointer=0, GHR=0; this overrides rdy and all other inputs.
REQ-031 While in reset and during INIT: out_ready=0, out_fetcher_jump=0, out_fetcher_ghr=0.
REQ-032 rst asserted in RUN or mid-INIT restarts INIT from entry 0; table contents before re-initialisation are don't-care.

Verification
REQ-033 Init: IDX_W=4, rst for 1 cycle, rdy=1 -> out_ready rises after exactly 16 cycles; every entry then predicts 0 (CTR_W=2, value 01).
REQ-034 Saturation: 5 commits taken to idx 3 with GHR=0 -> counter 11, predicts 1; then 4 not-taken -> counter 00, a 5th not-taken stays 00.
REQ-035 Speculative shift: GHR=0, three fetches with in_fetcher_br=1 predicting 1,0,1 -> out_fetcher_ghr = ...101.
REQ-036 Recovery priority: same cycle in_fetcher_br=1 and mispredict with in_rob_ghr=8'h3C, in_rob_jump=1 -> GHR=8'h79.
REQ-037 Stall/mid-init reset: rdy=0 for 3 cycles during INIT -> INIT is extended by 3 cycles; rst at pointer=7 -> pointer=0 and out_ready stays 0 for a full 2^IDX_W cycles.
REQ-038 Aliasing: commits taken on tag 5/ghr 0 and on tag 4/ghr 1 -> both hit entry 5, and the counter reflects both updates.
